// File: rtl/hero_pkg.sv
// Shared hero definitions: direction and FSM encodings, default geometry and a bounds helper.
// Used by the hero movement controller, the map unit and the level manager.
package hero_pkg;

  localparam int POS_W = 12;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVE    = 2'd1,
    ST_RESPAWN = 2'd2
  } state_e;

  localparam int START_X_DEF  = 481;
  localparam int START_Y_DEF  = 588;
  localparam int TILE_DEF     = 32;
  localparam int STEP_PX_DEF  = 4;
  localparam int STEP_DIV_DEF = 650000;
  localparam int X_MIN_DEF    = 33;
  localparam int X_MAX_DEF    = 929;
  localparam int Y_MIN_DEF    = 76;
  localparam int Y_MAX_DEF    = 716;

  // Operates on one extra bit so a target computed below zero reads as out of range.
  function automatic logic in_bounds(input logic [POS_W:0] v, input int lo, input int hi);
    return (v >= (POS_W+1)'(lo)) && (v <= (POS_W+1)'(hi));
  endfunction

endpackage

// File: rtl/hero_move_ctl_if.sv
// Signal bundle between the hero movement controller and its environment (keys, map unit, level manager).
// key_run only exists when HERO_RUN_EN is defined.
interface hero_move_ctl_if;

  logic key_up;
  logic key_down;
  logic key_left;
  logic key_right;
`ifdef HERO_RUN_EN
  logic key_run;
`endif
  logic hero_rst;
  logic dir_blocked;
  logic [1:0] dir_req;
  logic [hero_pkg::POS_W-1:0] hero_x_pos;
  logic [hero_pkg::POS_W-1:0] hero_y_pos;
  logic moving;
  logic [1:0] dir;

  modport master (
`ifdef HERO_RUN_EN
    output key_run,
`endif
    output key_up, key_down, key_left, key_right,
    output hero_rst, dir_blocked,
    input  dir_req, hero_x_pos, hero_y_pos, moving, dir
  );

  modport slave (
`ifdef HERO_RUN_EN
    input  key_run,
`endif
    input  key_up, key_down, key_left, key_right,
    input  hero_rst, dir_blocked,
    output dir_req, hero_x_pos, hero_y_pos, moving, dir
  );

endinterface

// File: rtl/hero_move_ctl_step_tick_gen.sv
// Step prescaler: counts 0..STEP_DIV-1 (or 0..STEP_DIV/2-1 with half_i) and flags the terminal count.
module step_tick_gen #(
  parameter int unsigned STEP_DIV = 650000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic half_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] TERM_FULL = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] TERM_HALF = CNT_W'(STEP_DIV / 2 - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] term;

  assign term = half_i ? TERM_HALF : TERM_FULL;

  // >= so a switch to half rate while the count is already past the half terminal still fires.
  assign tick_o = en_i && !clr_i && (cnt_q >= term);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hero_move_ctl.sv
// Hero movement controller: tile-stepped motion from held keys with wall query, bounds check and respawn.
// Optional HERO_RUN_EN adds key_run, which halves the step period while held.
module hero_move_ctl
  import hero_pkg::*;
#(
  parameter int START_X  = START_X_DEF,
  parameter int START_Y  = START_Y_DEF,
  parameter int TILE     = TILE_DEF,
  parameter int STEP_PX  = STEP_PX_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF,
  parameter int X_MIN    = X_MIN_DEF,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int Y_MIN    = Y_MIN_DEF,
  parameter int Y_MAX    = Y_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  hero_move_ctl_if.slave  bus
);

  localparam logic [POS_W-1:0] START_X_V = POS_W'(START_X);
  localparam logic [POS_W-1:0] START_Y_V = POS_W'(START_Y);
  localparam logic [POS_W-1:0] TILE_V    = POS_W'(TILE);
  localparam logic [POS_W-1:0] STEP_V    = POS_W'(STEP_PX);
  localparam logic [POS_W:0]   TILE_W    = (POS_W+1)'(TILE);

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [POS_W-1:0] x_q, x_d;
  logic [POS_W-1:0] y_q, y_d;
  logic [POS_W-1:0] remain_q, remain_d;

  dir_e             dir_req;
  logic             any_key;
  logic [POS_W:0]   x_wide, y_wide;
  logic [POS_W:0]   tgt;
  logic             tgt_ok;
  logic             start_ok;
  logic             presc_clr;
  logic             tick;
  logic             half_rate;

  always_comb begin
    dir_req = DIR_UP;
    if (bus.key_up) begin
      dir_req = DIR_UP;
    end else if (bus.key_down) begin
      dir_req = DIR_DOWN;
    end else if (bus.key_left) begin
      dir_req = DIR_LEFT;
    end else if (bus.key_right) begin
      dir_req = DIR_RIGHT;
    end
  end

  assign any_key = bus.key_up | bus.key_down | bus.key_left | bus.key_right;
  assign x_wide  = {1'b0, x_q};
  assign y_wide  = {1'b0, y_q};

  always_comb begin
    tgt    = '0;
    tgt_ok = 1'b0;
    unique case (dir_req)
      DIR_UP: begin
        tgt    = y_wide - TILE_W;
        tgt_ok = in_bounds(tgt, Y_MIN, Y_MAX);
      end
      DIR_DOWN: begin
        tgt    = y_wide + TILE_W;
        tgt_ok = in_bounds(tgt, Y_MIN, Y_MAX);
      end
      DIR_LEFT: begin
        tgt    = x_wide - TILE_W;
        tgt_ok = in_bounds(tgt, X_MIN, X_MAX);
      end
      DIR_RIGHT: begin
        tgt    = x_wide + TILE_W;
        tgt_ok = in_bounds(tgt, X_MIN, X_MAX);
      end
      default: begin
        tgt    = '0;
        tgt_ok = 1'b0;
      end
    endcase
  end

  assign start_ok = any_key && !bus.dir_blocked && tgt_ok;

`ifdef HERO_RUN_EN
  assign half_rate = bus.key_run;
`else
  assign half_rate = 1'b0;
`endif

  step_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_step_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (presc_clr),
    .en_i   (state_q == ST_MOVE),
    .half_i (half_rate),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    remain_d  = remain_q;
    presc_clr = 1'b0;

    // Respawn overrides everything, including a tick landing in the same cycle.
    if (bus.hero_rst) begin
      state_d   = ST_RESPAWN;
      x_d       = START_X_V;
      y_d       = START_Y_V;
      remain_d  = '0;
      presc_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_d   = ST_MOVE;
            dir_d     = dir_req;
            remain_d  = TILE_V;
            presc_clr = 1'b1;
          end
        end
        ST_MOVE: begin
          if (tick) begin
            unique case (dir_q)
              DIR_UP:    y_d = y_q - STEP_V;
              DIR_DOWN:  y_d = y_q + STEP_V;
              DIR_LEFT:  x_d = x_q - STEP_V;
              DIR_RIGHT: x_d = x_q + STEP_V;
              default:   x_d = x_q;
            endcase
            remain_d = remain_q - STEP_V;
            if (remain_q == STEP_V) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_RESPAWN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_UP;
      x_q      <= START_X_V;
      y_q      <= START_Y_V;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      remain_q <= remain_d;
    end
  end

  assign bus.dir_req    = dir_req;
  assign bus.hero_x_pos = x_q;
  assign bus.hero_y_pos = y_q;
  assign bus.moving     = (state_q == ST_MOVE);
  assign bus.dir        = dir_q;

endmodule

// File: tb/tb_hero_move_ctl.sv
// Scoreboard bench for hero_move_ctl: directed wall/respawn/reset sequences plus random traffic,
// expected outputs from a move-age based reference model, compared every cycle by a monitor.
module tb_hero_move_ctl;

  localparam int SX    = 481;
  localparam int SY    = 588;
  localparam int TILE  = 32;
  localparam int SPX   = 4;
  localparam int SDIV  = 4;
  localparam int XMIN  = 33;
  localparam int XMAX  = 929;
  localparam int YMIN  = 76;
  localparam int YMAX  = 716;
  localparam int TILE_CYC = (TILE / SPX) * SDIV;

  typedef struct {
    int   x;
    int   y;
    logic mv;
    int   d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  hero_move_ctl_if hif();

  hero_move_ctl #(
    .STEP_DIV (SDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int moves_done = 0;

  exp_t sbq[$];
  int   dq[$];

  // Reference model state: a move is tracked by its origin and edges elapsed since it began.
  int m_x, m_y, m_sx, m_sy, m_age, m_dir;
  bit m_mv, m_resp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int prio(input logic [3:0] k);
    for (int i = 0; i < 4; i++) begin
      if (k[i]) return i;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    m_x = SX; m_y = SY; m_mv = 0; m_resp = 0; m_dir = 0; m_age = 0; m_sx = SX; m_sy = SY;
  endfunction

  function automatic void model_step(input logic [3:0] k, input logic blk, input logic hr);
    int n, tx, ty, d;
    if (hr) begin
      m_x = SX; m_y = SY; m_mv = 0; m_resp = 1;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_mv) begin
      m_age++;
      n = SPX * (m_age / SDIV);
      case (m_dir)
        0: m_y = m_sy - n;
        1: m_y = m_sy + n;
        2: m_x = m_sx - n;
        default: m_x = m_sx + n;
      endcase
      if (m_age == TILE_CYC) m_mv = 0;
    end else if (k != 4'b0 && !blk) begin
      d = prio(k);
      tx = m_x; ty = m_y;
      case (d)
        0: ty = m_y - TILE;
        1: ty = m_y + TILE;
        2: tx = m_x - TILE;
        default: tx = m_x + TILE;
      endcase
      if (tx >= XMIN && tx <= XMAX && ty >= YMIN && ty <= YMAX) begin
        m_mv = 1; m_dir = d; m_age = 0; m_sx = m_x; m_sy = m_y;
      end
    end
  endfunction

  // One stimulus cycle: k = {right,left,down,up}.
  task automatic drive(input logic rn, input logic [3:0] k, input logic blk, input logic hr);
    exp_t e;
    @(posedge clk);
    #1;
    if (!rn) model_reset();
    rst_n = rn;
    e.x = m_x; e.y = m_y; e.mv = m_mv; e.d = m_dir;
    sbq.push_back(e);
    hif.key_up      = k[0];
    hif.key_down    = k[1];
    hif.key_left    = k[2];
    hif.key_right   = k[3];
    hif.dir_blocked = blk;
    hif.hero_rst    = hr;
    dq.push_back(prio(k));
    if (rn) model_step(k, blk, hr);
  endtask

  // Monitor: every cycle is a transaction; compare mid-cycle on the falling edge.
  logic prev_mv = 1'b0;
  initial begin
    exp_t e;
    int ed;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("hero_x_pos", 32'(hif.hero_x_pos), 32'(e.x));
        check("hero_y_pos", 32'(hif.hero_y_pos), 32'(e.y));
        check("moving", 32'(hif.moving), 32'(e.mv));
        check("dir", 32'(hif.dir), 32'(e.d));
        if (prev_mv && !hif.moving && rst_n) begin
          moves_done++;
          $display("move %0d done: dir=%0d pos=(%0d,%0d)", moves_done, hif.dir, hif.hero_x_pos, hif.hero_y_pos);
        end
        prev_mv = hif.moving;
      end
      if (dq.size() > 0) begin
        ed = dq.pop_front();
        check("dir_req", 32'(hif.dir_req), 32'(ed));
      end
    end
  end

  initial begin
    logic [3:0] k;
    logic blk, hr, rn;
    hif.key_up = 0; hif.key_down = 0; hif.key_left = 0; hif.key_right = 0;
    hif.dir_blocked = 0; hif.hero_rst = 0;
`ifdef HERO_RUN_EN
    hif.key_run = 0;
`endif
    model_reset();

    repeat (3) drive(0, 4'b0000, 0, 0);
    drive(1, 4'b0001, 0, 0);
    repeat (40) drive(1, 4'b0000, 0, 0);
    drive(1, 4'b0101, 0, 0);
    repeat (40) drive(1, 4'b0000, 0, 0);
    repeat (10) drive(1, 4'b0100, 1, 0);
    repeat (560) drive(1, 4'b1000, 0, 0);
    repeat (560) drive(1, 4'b0001, 0, 0);

    // Respawn mid-move at y=572, key held alongside and through RESPAWN.
    drive(1, 4'b0000, 0, 1);
    drive(1, 4'b0000, 0, 0);
    drive(1, 4'b0001, 0, 0);
    repeat (16) drive(1, 4'b0000, 0, 0);
    drive(1, 4'b0001, 0, 1);
    drive(1, 4'b0001, 0, 0);
    repeat (40) drive(1, 4'b0000, 0, 0);

    repeat (520) drive(1, 4'b0100, 0, 0);
    repeat (200) drive(1, 4'b0010, 0, 0);

    // Reset asserted mid-move.
    drive(1, 4'b0001, 0, 0);
    repeat (10) drive(1, 4'b0000, 0, 0);
    repeat (2) drive(0, 4'b0000, 0, 0);
    repeat (5) drive(1, 4'b0000, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      k   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      blk = ($urandom_range(0, 3) == 0);
      hr  = ($urandom_range(0, 63) == 0);
      rn  = ($urandom_range(0, 499) != 0);
      drive(rn, k, blk, hr);
    end
    drive(1, 4'b0000, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size() + dq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
